lif_ca_post_neuron: RTL and testbench
=====================================

// Module: lif_ca_post_neuron
// PURPOSE
//  Postsynaptic leaky integrate-and-fire neuron with a calcium trace. It sits directly
//  upstream of the voltage-dependent STDP synapse and drives that block's V_mem_post and
//  Ca_post inputs. On each time-step strobe it integrates the summed synaptic increment,
//  fires and resets at threshold, holds a refractory period, and updates the calcium trace.
// PARAMETERS
//  BW           32             width of V datapath; signed Q1.31 volts
//  CW           16             width of Ca trace; unsigned Q4.12
//  V_PEAK       32'h00000000   V_mem value driven on the spike step
//  V_RESET      32'hF70A0000   post-spike reset potential (-0.070 V)
//  V_TH         32'hF9A00000   firing threshold (-0.050 V)
//  V_REST       32'hF70A0000   leak target potential
//  LEAK_SHIFT   4              leak = (V_REST - V) >>> LEAK_SHIFT per step
//  T_REF        20             refractory length in steps; 0 = no refractory period
//  REF_W        8              refractory counter width; requires T_REF < 2**REF_W
//  J_CA         16'h0199       Ca increment per spike (0.1 in Q4.12)
//  TAU_CA_SHIFT 6              Ca decay = Ca >> TAU_CA_SHIFT per step
// PORTS
//  clk         in   1    clock
//  reset       in   1    synchronous, active-high
//  step        in   1    time-step strobe; one pulse = one 0.1 ms step
//  I_in        in   BW   signed dV increment for this step, already scaled
//  V_mem_post  out  BW   membrane potential (registered)
//  Ca_post     out  CW   calcium trace (registered)
//  spike_out   out  1    high for exactly 1 clk after a firing step
//  refractory  out  1    high while in the REFRACT state
//  valid       out  1    1-clk pulse when outputs have updated for a step
// BEHAVIOUR
//  - Reset: V_mem_post=V_RESET, Ca_post=0, spike_out=0, refractory=0, valid=0,
//    ref_cnt=0, state=INTEGRATE. Reset wins over step in the same cycle, and reset
//    mid-refractory aborts the refractory period.
//  - When step=0, all state holds and spike_out and valid are 0.
//  - Latency: outputs update on the clk edge that samples step=1; valid pulses that same cycle.
//  - FSM, evaluated only when step=1:
//    INTEGRATE: Vn = V + I_in + ((V_REST - V) >>> LEAK_SHIFT).
//      Sum uses BW+2 signed bits, then saturates to [0x80000000, 0x7FFFFFFF].
//      If Vn >= V_TH (signed compare): V_mem_post=V_PEAK, spike_out=1, go to SPIKE.
//      Otherwise V_mem_post=Vn.
//    SPIKE (one step): V_mem_post=V_RESET and I_in is ignored.
//      If T_REF=0, go to INTEGRATE; otherwise ref_cnt=T_REF-1, refractory=1, go to REFRACT.
//    REFRACT: V_mem_post held at V_RESET and I_in ignored.
//      If ref_cnt==0: refractory=0, go to INTEGRATE; otherwise ref_cnt decrements.
//      The neuron therefore spends T_REF steps in REFRACT.
//  - Ca update, every step and in all states:
//    dec = Ca >> TAU_CA_SHIFT; if dec==0 and Ca!=0 then dec=1.
//    Ca' = Ca - dec, then + J_CA if this step fires; the add saturates at 16'hFFFF.
//    Decay is applied before the increment on the firing step.
//    Ca_post=0 with no spike stays at 0 (no underflow).
//  - A spike is only ever detected in INTEGRATE, so there are no back-to-back spikes.
// STRUCTURE
//  - Shared package snn_fixed_pkg: the Q-format widths, V_PEAK/V_RESET/V_TH/V_REST,
//    J_CA, and the FSM state encoding localparams (INTEGRATE=0, SPIKE=1, REFRACT=2).
//    The synapse block consumes the same constants.
//  - One sub-module, ca_trace: decay, spike increment and saturation, ports
//    (clk, reset, step, fire, Ca).
//  - The LIF datapath and FSM stay in the top module.
// TESTING
//  1. reset, then 10 steps with I_in=0 -> V_mem_post stays 0xF70A0000;
//     Ca_post=0; spike_out never asserts; valid pulses 10 times.
//  2. I_in=32'h02000000 held -> after step 1 V_mem_post=0xF90A0000;
//     step 2 spikes (Vn=0xFAEA0000>=V_TH), V_mem_post=0x00000000, spike_out=1 for 1 clk;
//     Ca_post=0x0199.
//  3. Continue test 2 -> step 3 V_mem_post=V_RESET; refractory=1 for the next 20 steps;
//     V held and I_in ignored; the first spike after that comes no earlier than 2 steps
//     past refractory release.
//  4. Ca decay: Ca_post=0x0199 with no spikes -> next step 0x0193 (dec=6);
//     once Ca_post<64 it falls by 1 per step and settles at 0.
//  5. Saturation: I_in=32'h7FFFFFFF -> no signed wrap; spike on the 1st step.
//     Force repeated spikes with J_CA=16'hF000 -> Ca_post clamps at 16'hFFFF.
//  6. reset asserted mid-REFRACT together with step=1 -> next clk all outputs are at their
//     reset values; with I_in=32'h02000000 the next spike comes 2 steps later.

Source files
------------

// File: rtl/snn_fixed_pkg.sv
// Fixed-point formats and shared constants for the SNN neuron/synapse blocks.
// V is signed Q1.31 volts, Ca is unsigned Q4.12.
package snn_fixed_pkg;

    localparam int SNN_BW = 32;
    localparam int SNN_CW = 16;

    localparam logic [SNN_BW-1:0] SNN_V_PEAK  = 32'h0000_0000;
    localparam logic [SNN_BW-1:0] SNN_V_RESET = 32'hF70A_0000;  // -0.070 V
    localparam logic [SNN_BW-1:0] SNN_V_TH    = 32'hF9A0_0000;  // -0.050 V
    localparam logic [SNN_BW-1:0] SNN_V_REST  = 32'hF70A_0000;

    localparam logic [SNN_CW-1:0] SNN_J_CA = 16'h0199;  // 0.1 in Q4.12

    localparam logic [1:0] ST_INTEGRATE = 2'd0;
    localparam logic [1:0] ST_SPIKE     = 2'd1;
    localparam logic [1:0] ST_REFRACT   = 2'd2;

    typedef enum logic [1:0] {
        INTEGRATE = ST_INTEGRATE,
        SPIKE     = ST_SPIKE,
        REFRACT   = ST_REFRACT
    } lif_state_e;

endpackage

// File: rtl/lif_ca_post_neuron_ca_trace.sv
// Calcium trace: per-step exponential decay, with an optional saturating increment
// on the firing step.
module ca_trace
    import snn_fixed_pkg::*;
#(
    parameter int              CW           = SNN_CW,
    parameter logic [CW-1:0]   J_CA         = SNN_J_CA,
    parameter int              TAU_CA_SHIFT = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          fire,
    output logic [CW-1:0] Ca
);

    logic [CW-1:0] ca_q, ca_d;
    logic [CW-1:0] dec;
    logic [CW-1:0] decayed;
    logic [CW:0]   sum;

    always_comb begin
        dec = ca_q >> TAU_CA_SHIFT;
        // Small traces still decay by one LSB, so the trace always reaches zero.
        if (dec == '0 && ca_q != '0) dec = CW'(1);
        decayed = ca_q - dec;
        sum     = {1'b0, decayed} + {1'b0, J_CA};
        ca_d    = ca_q;
        if (step) begin
            if (fire) ca_d = sum[CW] ? '1 : sum[CW-1:0];
            else      ca_d = decayed;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ca_q <= '0;
        else       ca_q <= ca_d;
    end

    assign Ca = ca_q;

endmodule

// File: rtl/lif_ca_post_neuron.sv
// Postsynaptic LIF neuron with a refractory FSM and a calcium trace. It drives the
// membrane potential and calcium inputs of the voltage-dependent STDP synapse.
module lif_ca_post_neuron
    import snn_fixed_pkg::*;
#(
    parameter int            BW           = SNN_BW,
    parameter int            CW           = SNN_CW,
    parameter logic [BW-1:0] V_PEAK       = SNN_V_PEAK,
    parameter logic [BW-1:0] V_RESET      = SNN_V_RESET,
    parameter logic [BW-1:0] V_TH         = SNN_V_TH,
    parameter logic [BW-1:0] V_REST       = SNN_V_REST,
    parameter int            LEAK_SHIFT   = 4,
    parameter int            T_REF        = 20,
    parameter int            REF_W        = 8,   // must satisfy T_REF < 2**REF_W
    parameter logic [CW-1:0] J_CA         = SNN_J_CA,
    parameter int            TAU_CA_SHIFT = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic [BW-1:0] I_in,
    output logic [BW-1:0] V_mem_post,
    output logic [CW-1:0] Ca_post,
    output logic          spike_out,
    output logic          refractory,
    output logic          valid
);

    lif_state_e         state_q, state_d;
    logic [BW-1:0]      v_q, v_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               spike_q, valid_q;
    logic               fire;

    logic signed [BW+1:0] v_ext, i_ext, rest_ext, leak, vsum;
    logic        [BW-1:0] vn;

    // Two guard bits keep V + I + leak exact before saturating back to BW bits.
    always_comb begin
        v_ext    = {{2{v_q[BW-1]}}, v_q};
        i_ext    = {{2{I_in[BW-1]}}, I_in};
        rest_ext = {{2{V_REST[BW-1]}}, V_REST};
        leak     = (rest_ext - v_ext) >>> LEAK_SHIFT;
        vsum     = v_ext + i_ext + leak;
        if (vsum[BW+1:BW-1] == 3'b000 || vsum[BW+1:BW-1] == 3'b111)
            vn = vsum[BW-1:0];
        else
            vn = vsum[BW+1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        ref_cnt_d = ref_cnt_q;
        fire      = 1'b0;
        if (step) begin
            case (state_q)
                INTEGRATE: begin
                    if ($signed(vn) >= $signed(V_TH)) begin
                        v_d     = V_PEAK;
                        fire    = 1'b1;
                        state_d = SPIKE;
                    end else begin
                        v_d = vn;
                    end
                end
                SPIKE: begin
                    v_d = V_RESET;
                    if (T_REF == 0) begin
                        state_d = INTEGRATE;
                    end else begin
                        ref_cnt_d = REF_W'(T_REF - 1);
                        state_d   = REFRACT;
                    end
                end
                REFRACT: begin
                    v_d = V_RESET;
                    if (ref_cnt_q == '0) state_d = INTEGRATE;
                    else                 ref_cnt_d = ref_cnt_q - 1'b1;
                end
                default: begin
                    v_d     = V_RESET;
                    state_d = INTEGRATE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INTEGRATE;
            v_q       <= V_RESET;
            ref_cnt_q <= '0;
            spike_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            ref_cnt_q <= ref_cnt_d;
            spike_q   <= fire;
            valid_q   <= step;
        end
    end

    ca_trace #(
        .CW           (CW),
        .J_CA         (J_CA),
        .TAU_CA_SHIFT (TAU_CA_SHIFT)
    ) u_ca_trace (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .fire  (fire),
        .Ca    (Ca_post)
    );

    assign V_mem_post = v_q;
    assign spike_out  = spike_q;
    assign refractory = (state_q == REFRACT);
    assign valid      = valid_q;

endmodule

// File: tb/tb_lif_ca_post_neuron.sv
// Directed bench for lif_ca_post_neuron: default instance plus a T_REF=0,
// large-J_CA instance used for calcium saturation.
module tb_lif_ca_post_neuron;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic [31:0] I_in = '0;

    logic [31:0] v_mem, sat_v;
    logic [15:0] ca, sat_ca;
    logic        spk, refr, vld, sat_spk, sat_refr, sat_vld;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] VRST = 32'hF70A0000;

    always #5 clk = ~clk;

    lif_ca_post_neuron u_dut (
        .clk(clk), .reset(reset), .step(step), .I_in(I_in),
        .V_mem_post(v_mem), .Ca_post(ca), .spike_out(spk),
        .refractory(refr), .valid(vld)
    );

    lif_ca_post_neuron #(.T_REF(0), .J_CA(16'hF000)) u_sat (
        .clk(clk), .reset(reset), .step(step), .I_in(I_in),
        .V_mem_post(sat_v), .Ca_post(sat_ca), .spike_out(sat_spk),
        .refractory(sat_refr), .valid(sat_vld)
    );

    task automatic do_step(input logic [31:0] i);
        @(negedge clk);
        I_in = i;
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (v_mem !== VRST) begin errors++; $display("FAIL reset_v: got %h want %h", v_mem, VRST); end
        checks++; if (ca !== 16'h0) begin errors++; $display("FAIL reset_ca: got %h want 0000", ca); end
        checks++; if ({spk, refr, vld} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {spk, refr, vld}); end
    endtask

    task automatic test_idle();
        int nvalid = 0;
        int nspike = 0;
        for (int k = 0; k < 10; k++) begin
            do_step(32'h0);
            nvalid += int'(vld);
            nspike += int'(spk);
        end
        checks++; if (nvalid != 10) begin errors++; $display("FAIL idle_valid_count: got %0d want 10", nvalid); end
        checks++; if (nspike != 0) begin errors++; $display("FAIL idle_spikes: got %0d want 0", nspike); end
        checks++; if (v_mem !== VRST) begin errors++; $display("FAIL idle_v: got %h want %h", v_mem, VRST); end
        checks++; if (ca !== 16'h0) begin errors++; $display("FAIL idle_ca: got %h want 0000", ca); end
        @(negedge clk); I_in = 32'h02000000;
        @(posedge clk); #1;
        checks++; if (vld !== 1'b0 || v_mem !== VRST) begin errors++; $display("FAIL hold_no_step: got vld=%b v=%h want 0/%h", vld, v_mem, VRST); end
    endtask

    task automatic test_spike_refract();
        do_reset();
        do_step(32'h02000000);
        checks++; if (v_mem !== 32'hF90A0000 || spk !== 1'b0) begin errors++; $display("FAIL step1_v: got %h spk=%b want f90a0000/0", v_mem, spk); end
        do_step(32'h02000000);
        checks++; if (v_mem !== 32'h0 || spk !== 1'b1) begin errors++; $display("FAIL step2_spike: got %h spk=%b want 00000000/1", v_mem, spk); end
        checks++; if (ca !== 16'h0199) begin errors++; $display("FAIL step2_ca: got %h want 0199", ca); end
        @(posedge clk); #1;
        checks++; if (spk !== 1'b0) begin errors++; $display("FAIL spike_width: got %b want 0", spk); end
        do_step(32'h02000000);
        checks++; if (v_mem !== VRST || refr !== 1'b1 || spk !== 1'b0) begin errors++; $display("FAIL step3_spike_state: got %h refr=%b want %h/1", v_mem, refr, VRST); end
        checks++; if (ca !== 16'h0193) begin errors++; $display("FAIL step3_ca: got %h want 0193", ca); end
        for (int k = 4; k <= 22; k++) begin
            do_step(32'h7FFFFFFF);
            checks++; if (v_mem !== VRST || refr !== 1'b1 || spk !== 1'b0) begin errors++; $display("FAIL refract_step%0d: got v=%h refr=%b spk=%b want %h/1/0", k, v_mem, refr, spk, VRST); end
        end
        do_step(32'h7FFFFFFF);
        checks++; if (v_mem !== VRST || refr !== 1'b0 || spk !== 1'b0) begin errors++; $display("FAIL refract_release: got v=%h refr=%b want %h/0", v_mem, refr, VRST); end
        do_step(32'h02000000);
        checks++; if (v_mem !== 32'hF90A0000 || spk !== 1'b0) begin errors++; $display("FAIL post_ref_step1: got %h spk=%b want f90a0000/0", v_mem, spk); end
        do_step(32'h02000000);
        checks++; if (spk !== 1'b1 || v_mem !== 32'h0) begin errors++; $display("FAIL post_ref_spike: got %h spk=%b want 00000000/1", v_mem, spk); end
    endtask

    task automatic test_ca_decay();
        logic [15:0] prev;
        int nspike = 0;
        do_reset();
        do_step(32'h02000000);
        do_step(32'h02000000);
        do_step(32'h0);
        checks++; if (ca !== 16'h0193) begin errors++; $display("FAIL decay_1: got %h want 0193", ca); end
        do_step(32'h0);
        checks++; if (ca !== 16'h018D) begin errors++; $display("FAIL decay_2: got %h want 018d", ca); end
        for (int k = 0; k < 400; k++) begin
            prev = ca;
            do_step(32'h0);
            nspike += int'(spk);
            if (prev < 16'd64) begin
                checks++;
                if (ca !== ((prev == 16'h0) ? 16'h0 : prev - 16'd1)) begin
                    errors++; $display("FAIL decay_small: from %h got %h", prev, ca);
                end
            end
        end
        checks++; if (ca !== 16'h0) begin errors++; $display("FAIL decay_settle: got %h want 0000", ca); end
        checks++; if (nspike != 0 || v_mem !== VRST) begin errors++; $display("FAIL decay_quiet: got spikes=%0d v=%h want 0/%h", nspike, v_mem, VRST); end
    endtask

    task automatic test_saturation();
        do_reset();
        do_step(32'h80000000);
        checks++; if (v_mem !== 32'h80000000) begin errors++; $display("FAIL sat_neg: got %h want 80000000", v_mem); end
        do_step(32'h0);
        checks++; if (v_mem !== 32'h8770A000) begin errors++; $display("FAIL sat_neg_leak: got %h want 8770a000", v_mem); end
        do_reset();
        do_step(32'h7FFFFFFF);
        checks++; if (spk !== 1'b1 || v_mem !== 32'h0) begin errors++; $display("FAIL sat_pos_spike: got %h spk=%b want 00000000/1", v_mem, spk); end
        checks++; if (sat_spk !== 1'b1 || sat_ca !== 16'hF000) begin errors++; $display("FAIL sat_ca_1: got %h spk=%b want f000/1", sat_ca, sat_spk); end
        do_step(32'h7FFFFFFF);
        checks++; if (sat_spk !== 1'b0 || sat_ca !== 16'hEC40 || sat_refr !== 1'b0) begin errors++; $display("FAIL sat_ca_2: got %h spk=%b refr=%b want ec40/0/0", sat_ca, sat_spk, sat_refr); end
        do_step(32'h7FFFFFFF);
        checks++; if (sat_spk !== 1'b1 || sat_ca !== 16'hFFFF) begin errors++; $display("FAIL sat_ca_clamp: got %h spk=%b want ffff/1", sat_ca, sat_spk); end
        do_step(32'h7FFFFFFF);
        checks++; if (sat_ca !== 16'hFC00) begin errors++; $display("FAIL sat_ca_decay: got %h want fc00", sat_ca); end
        do_step(32'h7FFFFFFF);
        checks++; if (sat_ca !== 16'hFFFF) begin errors++; $display("FAIL sat_ca_clamp2: got %h want ffff", sat_ca); end
    endtask

    task automatic test_reset_refract();
        do_reset();
        do_step(32'h02000000);
        do_step(32'h02000000);
        do_step(32'h02000000);
        do_step(32'h02000000);
        checks++; if (refr !== 1'b1) begin errors++; $display("FAIL pre_abort_refr: got %b want 1", refr); end
        @(negedge clk);
        reset = 1'b1;
        step  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        step  = 1'b0;
        checks++; if (v_mem !== VRST || ca !== 16'h0) begin errors++; $display("FAIL abort_vals: got v=%h ca=%h want %h/0000", v_mem, ca, VRST); end
        checks++; if ({spk, refr, vld} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b want 000", {spk, refr, vld}); end
        do_step(32'h02000000);
        checks++; if (spk !== 1'b0 || v_mem !== 32'hF90A0000) begin errors++; $display("FAIL abort_step1: got %h spk=%b want f90a0000/0", v_mem, spk); end
        do_step(32'h02000000);
        checks++; if (spk !== 1'b1) begin errors++; $display("FAIL abort_step2_spike: got %b want 1", spk); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_spike_refract();
        test_ca_decay();
        test_saturation();
        test_reset_refract();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
